// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift-register sequencer: downstream mode codes,
// FSM states and the queued command entry.
package shift_seq_pkg;

    // {s1,s0} mode codes understood by the downstream universal shift register
    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] SHR  = 2'b01;
    localparam logic [1:0] SHL  = 2'b10;
    localparam logic [1:0] LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] word;
        logic       dir;
        logic [2:0] len;
        logic       fill;
    } cmd_t;

    localparam int CMD_W = 9;

    localparam logic [2:0] MAX_LEN = 3'd4;

    function automatic logic [2:0] clamp_len(input logic [2:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO: power-of-two depth, registered empty/full and a registered
// ready that stays low while reset is applied.
module cmd_fifo
    import shift_seq_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t head,
    output logic empty,
    output logic ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic [AW:0]   count_n;
    logic          full;
    logic          do_push;
    logic          do_pop;

    // Popping frees the head slot first, so a push into a full FIFO is legal
    // in the same cycle as a pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rptr];

    always_comb begin
        count_n = count;
        if (do_push && !do_pop) begin
            count_n = count + (AW + 1)'(1);
        end else if (!do_push && do_pop) begin
            count_n = count - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
            ready <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count_n;
            empty <= (count_n == '0);
            full  <= (count_n == FULL_CNT);
            ready <= (count_n != FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/shift_reg_sequencer.sv
// Sequencer that turns queued (word, dir, len, fill) commands into mode/data
// drive for a downstream 4-bit universal shift register.
module shift_reg_sequencer
    import shift_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_word,
    input  logic       cmd_dir,
    input  logic [2:0] cmd_len,
    input  logic       cmd_fill,
    input  logic       pause,
    output logic       s1,
    output logic       s0,
    output logic [3:0] Data_In,
    output logic       MSB_In,
    output logic       LSB_In,
    output logic       busy,
    output logic       done
);

    // Handshake: a command transfers on every rising clk edge where cmd_valid
    // and cmd_ready are both high; cmd_ready never depends on cmd_valid.
    cmd_t       push_data;
    cmd_t       head;
    logic       fifo_empty;
    logic       pop;

    assign push_data = '{word: cmd_word, dir: cmd_dir, len: cmd_len, fill: cmd_fill};

    cmd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (cmd_valid & cmd_ready),
        .push_data(push_data),
        .pop      (pop),
        .head     (head),
        .empty    (fifo_empty),
        .ready    (cmd_ready)
    );

    state_t     state, state_n;
    cmd_t       cur, cur_n;
    logic [2:0] cnt, cnt_n;
    logic [1:0] mode, mode_n;
    logic [3:0] data_n;
    logic       msb_n, lsb_n, done_n;
    logic       active;

    // A LOAD/SHIFT cycle whose registered mode is non-HOLD actually issued
    // its operation; a HOLD there marks a paused cycle that must repeat.
    assign active = (mode != HOLD);

    always_comb begin
        state_n = state;
        cur_n   = cur;
        cnt_n   = cnt;
        pop     = 1'b0;
        mode_n  = HOLD;
        data_n  = 4'd0;
        msb_n   = 1'b0;
        lsb_n   = 1'b0;
        done_n  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!fifo_empty && !pause) begin
                    pop     = 1'b1;
                    cur_n   = head;
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (active) begin
                    cnt_n   = clamp_len(cur.len);
                    state_n = (clamp_len(cur.len) == 3'd0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (active) begin
                    cnt_n = cnt - 3'd1;
                    if (cnt == 3'd1) state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!fifo_empty && !pause) begin
                    pop     = 1'b1;
                    cur_n   = head;
                    state_n = ST_LOAD;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they line up with it
        case (state_n)
            ST_LOAD: begin
                if (!pause) begin
                    mode_n = LOAD;
                    data_n = cur_n.word;
                end
            end
            ST_SHIFT: begin
                if (!pause) begin
                    if (cur_n.dir) begin
                        mode_n = SHL;
                        lsb_n  = cur_n.fill;
                    end else begin
                        mode_n = SHR;
                        msb_n  = cur_n.fill;
                    end
                end
            end
            ST_DONE: done_n = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cur     <= '0;
            cnt     <= 3'd0;
            mode    <= HOLD;
            Data_In <= 4'd0;
            MSB_In  <= 1'b0;
            LSB_In  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cur     <= cur_n;
            cnt     <= cnt_n;
            mode    <= mode_n;
            Data_In <= data_n;
            MSB_In  <= msb_n;
            LSB_In  <= lsb_n;
            busy    <= (state_n != ST_IDLE);
            done    <= done_n;
        end
    end

    assign s1 = mode[1];
    assign s0 = mode[0];

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench for shift_reg_sequencer with a behavioural downstream
// shift register and hand-computed expectations.
module tb_shift_reg_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_word;
    logic       cmd_dir;
    logic [2:0] cmd_len;
    logic       cmd_fill;
    logic       pause;
    logic       s1, s0;
    logic [3:0] Data_In;
    logic       MSB_In, LSB_In;
    logic       busy, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_reg_sequencer #(
        .FIFO_DEPTH(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_word (cmd_word),
        .cmd_dir  (cmd_dir),
        .cmd_len  (cmd_len),
        .cmd_fill (cmd_fill),
        .pause    (pause),
        .s1       (s1),
        .s0       (s0),
        .Data_In  (Data_In),
        .MSB_In   (MSB_In),
        .LSB_In   (LSB_In),
        .busy     (busy),
        .done     (done)
    );

    // Downstream register plus activity counters
    logic [3:0] model_q     = 4'd0;
    logic       prev_done   = 1'b0;
    int         shift_total = 0;
    int         done_total  = 0;
    int         chain_total = 0;
    logic [3:0] load_log[$];

    always @(posedge clk) begin
        prev_done <= done;
        if (done) done_total <= done_total + 1;
        case ({s1, s0})
            2'b11: begin
                model_q <= Data_In;
                load_log.push_back(Data_In);
                if (prev_done) chain_total <= chain_total + 1;
            end
            2'b01: begin
                model_q     <= {MSB_In, model_q[3:1]};
                shift_total <= shift_total + 1;
            end
            2'b10: begin
                model_q     <= {model_q[2:0], LSB_In};
                shift_total <= shift_total + 1;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] w, input logic d, input logic [2:0] l, input logic f);
        cmd_word  = w;
        cmd_dir   = d;
        cmd_len   = l;
        cmd_fill  = f;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        for (int i = 0; i < bound && done !== 1'b1; i++) step();
        chk(tag, done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_shift;
        int base_load;
        int base_chain;
        int base_done;

        rst = 1'b1; cmd_valid = 1'b0; cmd_word = 4'd0; cmd_dir = 1'b0;
        cmd_len = 3'd0; cmd_fill = 1'b0; pause = 1'b0;
        step();
        step();
        chk("rst_mode",  {s1, s0}, 2'b00);
        chk("rst_data",  Data_In, 4'd0);
        chk("rst_fill",  {MSB_In, LSB_In}, 2'b00);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_ready", cmd_ready, 0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", cmd_ready, 1);
        chk("post_rst_busy",  busy, 0);

        // 1010 shift right twice with fill 1 -> 1110
        push(4'b1010, 1'b0, 3'd2, 1'b1);
        chk("t1_idle_gap", busy, 0);
        step();
        chk("t1_load_mode", {s1, s0}, 2'b11);
        chk("t1_load_data", Data_In, 4'b1010);
        chk("t1_load_busy", busy, 1);
        step();
        chk("t1_shr1_mode", {s1, s0}, 2'b01);
        chk("t1_shr1_fill", {MSB_In, LSB_In}, 2'b10);
        step();
        chk("t1_shr2_mode", {s1, s0}, 2'b01);
        step();
        chk("t1_done",      done, 1);
        chk("t1_done_mode", {s1, s0}, 2'b00);
        chk("t1_model",     model_q, 4'b1110);
        step();
        chk("t1_done_pulse", done, 0);
        chk("t1_idle_busy",  busy, 0);

        // Zero-length command: load then straight to done
        base_shift = shift_total;
        push(4'b0011, 1'b1, 3'd0, 1'b0);
        step();
        chk("t2_load_mode", {s1, s0}, 2'b11);
        chk("t2_load_data", Data_In, 4'b0011);
        step();
        chk("t2_done",   done, 1);
        chk("t2_mode",   {s1, s0}, 2'b00);
        chk("t2_shifts", shift_total - base_shift, 0);
        chk("t2_model",  model_q, 4'b0011);
        step();

        // len=7 clamps to 4 left shifts with fill 1
        base_shift = shift_total;
        push(4'b0000, 1'b1, 3'd7, 1'b1);
        step();
        chk("t3_load_mode", {s1, s0}, 2'b11);
        step();
        chk("t3_shl_mode", {s1, s0}, 2'b10);
        chk("t3_shl_fill", {MSB_In, LSB_In}, 2'b01);
        chk("t3_shl_data", Data_In, 4'd0);
        wait_done("t3_done", 10);
        chk("t3_shifts", shift_total - base_shift, 4);
        chk("t3_model",  model_q, 4'b1111);
        step();

        // Three back-to-back commands into a depth-2 FIFO
        base_load  = load_log.size();
        base_chain = chain_total;
        cmd_valid = 1'b1;
        cmd_word = 4'b0001; cmd_dir = 1'b0; cmd_len = 3'd4; cmd_fill = 1'b0;
        step();
        chk("t4_ready_a", cmd_ready, 1);
        cmd_word = 4'b0010; cmd_dir = 1'b1; cmd_len = 3'd1; cmd_fill = 1'b0;
        step();
        chk("t4_ready_b", cmd_ready, 1);
        cmd_word = 4'b0100; cmd_dir = 1'b0; cmd_len = 3'd0; cmd_fill = 1'b0;
        step();
        cmd_valid = 1'b0;
        chk("t4_full_ready", cmd_ready, 0);
        wait_done("t4_done_a", 20);
        step();
        chk("t4_chain_b_mode", {s1, s0}, 2'b11);
        chk("t4_chain_b_data", Data_In, 4'b0010);
        wait_done("t4_done_b", 20);
        step();
        chk("t4_chain_c_mode", {s1, s0}, 2'b11);
        chk("t4_chain_c_data", Data_In, 4'b0100);
        step();
        chk("t4_done_c", done, 1);
        step();
        chk("t4_idle_busy",  busy, 0);
        chk("t4_idle_ready", cmd_ready, 1);
        chk("t4_chains",     chain_total - base_chain, 2);
        chk("t4_log_size",   load_log.size() - base_load, 3);
        chk("t4_order_a",    load_log[base_load],     4'b0001);
        chk("t4_order_b",    load_log[base_load + 1], 4'b0010);
        chk("t4_order_c",    load_log[base_load + 2], 4'b0100);
        chk("t4_model",      model_q, 4'b0100);

        // Pause for three cycles in the middle of a 3-shift command
        base_shift = shift_total;
        push(4'b1000, 1'b0, 3'd3, 1'b0);
        step();
        chk("t5_load_mode", {s1, s0}, 2'b11);
        step();
        chk("t5_shift1", {s1, s0}, 2'b01);
        pause = 1'b1;
        step();
        chk("t5_pause1", {s1, s0}, 2'b00);
        chk("t5_pause_busy", busy, 1);
        step();
        chk("t5_pause2", {s1, s0}, 2'b00);
        step();
        chk("t5_pause3", {s1, s0}, 2'b00);
        pause = 1'b0;
        step();
        chk("t5_resume", {s1, s0}, 2'b01);
        wait_done("t5_done", 10);
        chk("t5_shifts", shift_total - base_shift, 3);
        chk("t5_model",  model_q, 4'b0001);
        step();

        // Reset in the middle of a shift abandons the command
        push(4'b1111, 1'b0, 3'd4, 1'b0);
        step();
        step();
        step();
        chk("t6_shift_mode", {s1, s0}, 2'b01);
        base_done = done_total;
        rst = 1'b1;
        step();
        chk("t6_rst_mode",  {s1, s0}, 2'b00);
        chk("t6_rst_data",  {Data_In, MSB_In, LSB_In}, 6'd0);
        chk("t6_rst_busy",  busy, 0);
        chk("t6_rst_done",  done, 0);
        chk("t6_rst_ready", cmd_ready, 0);
        rst = 1'b0;
        step();
        chk("t6_ready_back", cmd_ready, 1);
        chk("t6_busy_after", busy, 0);
        step();
        step();
        chk("t6_no_done",    done_total - base_done, 0);
        chk("t6_fifo_empty", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_reg_sequencer.md
SHIFT_REG_SEQUENCER -- requirements
Module: shift_reg_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning number of queued commands (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high on a clk edge.
REQ-006 SHALL have port cmd_word  input  4  parallel word to load.
REQ-007 SHALL have port cmd_dir  input  1  0 = shift right (fill at MSB), 1 = shift left (fill at LSB).
REQ-008 SHALL have port cmd_len  input  3  shift count after load; 0..4 valid, values 5..7 clamp to 4.
REQ-009 SHALL have port cmd_fill  input  1  serial fill bit driven during shifts.
REQ-010 SHALL have port pause  input  1  freezes sequencing while high.
REQ-011 SHALL have ports s1, s0  output  1 each  mode select to the downstream shift register.
REQ-012 SHALL have port Data_In  output  4  parallel load word to the downstream shift register.
REQ-013 SHALL have ports MSB_In, LSB_In  output  1 each  serial fill bits to the downstream shift register.
REQ-014 SHALL have port busy  output  1  high when the FSM is not IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse at end of each command.

Function
REQ-016 Mode encoding {s1,s0} SHALL be: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-017 Accepted commands SHALL enter a FIFO_DEPTH-entry FIFO, 9 bits per entry (word, dir, len, fill); cmd_ready = not full.
REQ-018 Push and pop SHALL be allowed in the same cycle, including when full; pop first frees the slot.
REQ-019 The FSM SHALL have states IDLE, LOAD, SHIFT, DONE.
REQ-020 In IDLE with the FIFO non-empty and pause low, the FSM SHALL pop the head entry and go to LOAD on the next edge.
REQ-021 In IDLE with pause high, the FSM SHALL stay in IDLE.
REQ-022 LOAD SHALL last one cycle: {s1,s0}=11, Data_In=word; then go to SHIFT if len>0, else to DONE.
REQ-023 SHIFT SHALL last exactly len non-paused cycles.
REQ-024 During SHIFT, {s1,s0} SHALL be 01 (dir=0) or 10 (dir=1); MSB_In=fill when dir=0 and LSB_In=fill when dir=1; the unused fill bit is 0.
REQ-025 A 3-bit down-counter SHALL track remaining shifts; it decrements only on non-paused SHIFT cycles.
REQ-026 Any pause-high cycle in LOAD or SHIFT SHALL drive {s1,s0}=00 and leave state and counter unchanged; the LOAD or shift is issued once pause drops.
REQ-027 DONE SHALL last one cycle: {s1,s0}=00 and done=1.
REQ-028 From DONE, the FSM SHALL go to LOAD if the FIFO is non-empty and pause is low (popping the next entry), else to IDLE.
REQ-029 Outside LOAD and SHIFT, {s1,s0} SHALL be 00 and Data_In, MSB_In, LSB_In SHALL be 0.
REQ-030 All outputs SHALL be registered; the mode and data for a state appear in the same cycle as that state.
REQ-031 Latency SHALL be: command accepted at edge N, with an empty FIFO and idle FSM, gives LOAD at cycle N+2.

Reset
REQ-032 When rst is high on a clk edge, the block SHALL clear the FIFO, go to IDLE and zero the counter.
REQ-033 While rst is high, outputs SHALL be: {s1,s0}=00, Data_In=0, MSB_In=0, LSB_In=0, busy=0, done=0, cmd_ready=0.
REQ-034 Reset asserted mid-command SHALL abandon that command with no done pulse; cmd_ready returns to 1 on the first cycle after rst drops.

Structure
REQ-035 A shared package shift_seq_pkg SHALL hold the mode constants (HOLD, SHR, SHL, LOAD), the FSM state enum and the command-entry struct/width.
REQ-036 The FIFO SHALL be a sub-module cmd_fifo (parameterised depth, registered full/empty); the FSM and counter SHALL reside in the top.

Verification
REQ-037 Push word=1010, dir=0, len=2, fill=1 -> one cycle of 11 with Data_In=1010, then two cycles of 01 with MSB_In=1, then done; a downstream model holds 1110.
REQ-038 Push word=0011, dir=1, len=0 -> one LOAD cycle, then done the next cycle; no shift cycles.
REQ-039 Push len=7 -> exactly 4 shift cycles.
REQ-040 Push three back-to-back commands with FIFO_DEPTH=2 -> cmd_ready drops while full; commands execute in order with DONE->LOAD chaining and no IDLE gap.
REQ-041 Raise pause for 3 cycles in mid-SHIFT with len=3 -> 00 during the pause; total shift cycles still 3.
REQ-042 Assert rst during SHIFT -> next cycle: outputs zero, busy=0, no done, FIFO empty.
